// File: rtl/cpu_define.sv
// Core-wide widths and shared types for the front end.
package cpu_define;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned PC_WIDTH   = 32;
    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
        logic                  filled;
    } fq_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// In-order fetch queue: allocate on issue, fill on response, pop to decode.
module ifu_fetch_queue
    import cpu_define::*;
#(
    parameter int unsigned FQ_DEPTH = 4,
    localparam int unsigned PtrW    = $clog2(FQ_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_i,
    input  logic [PC_WIDTH-1:0]   alloc_pc_i,
    input  logic                  fill_i,
    input  logic [INST_WIDTH-1:0] fill_inst_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic                  head_vld_o,
    output logic [PC_WIDTH-1:0]   head_pc_o,
    output logic [INST_WIDTH-1:0] head_inst_o,
    output logic [PtrW-1:0]       used_o,
    output logic [PtrW-1:0]       unfilled_o
);

    fq_entry_t        mem_q [FQ_DEPTH];
    logic [PtrW-1:0]  alloc_ptr_q, fill_ptr_q, head_ptr_q;
    logic [PtrW-2:0]  alloc_idx, fill_idx, head_idx;

    assign alloc_idx = alloc_ptr_q[PtrW-2:0];
    assign fill_idx  = fill_ptr_q[PtrW-2:0];
    assign head_idx  = head_ptr_q[PtrW-2:0];

    // Slot collisions cannot occur: alloc is blocked when full, and pop/fill
    // never target the same slot because pop requires the head to be filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            fill_ptr_q <= alloc_ptr_q;
            head_ptr_q <= alloc_ptr_q;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                mem_q[i].filled <= 1'b0;
            end
        end else begin
            if (alloc_i) begin
                mem_q[alloc_idx].pc     <= alloc_pc_i;
                mem_q[alloc_idx].filled <= 1'b0;
                alloc_ptr_q             <= alloc_ptr_q + PtrW'(1);
            end
            if (fill_i) begin
                mem_q[fill_idx].inst   <= fill_inst_i;
                mem_q[fill_idx].filled <= 1'b1;
                fill_ptr_q             <= fill_ptr_q + PtrW'(1);
            end
            // Clearing on pop keeps a stale filled bit from looking valid once empty.
            if (pop_i) begin
                mem_q[head_idx].filled <= 1'b0;
                head_ptr_q             <= head_ptr_q + PtrW'(1);
            end
        end
    end

    assign head_vld_o  = mem_q[head_idx].filled;
    assign head_pc_o   = mem_q[head_idx].pc;
    assign head_inst_o = mem_q[head_idx].inst;
    assign used_o      = alloc_ptr_q - head_ptr_q;
    assign unfilled_o  = alloc_ptr_q - fill_ptr_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential fetch, in-order queue, redirect flush.
// Optional perf counters enabled with IFU_FETCH_PERF_EN.
module ifu_fetch
    import cpu_define::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned         FQ_DEPTH = 4,
    localparam int unsigned        PtrW     = $clog2(FQ_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef IFU_FETCH_PERF_EN
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_drop_cnt,
`endif
    output logic                  ifu_req_addr_vld,
    output logic [ADDR_WIDTH-1:0] ifu_req_addr,
    input  logic                  ifu_req_data_vld,
    input  logic [DATA_WIDTH-1:0] ifu_req_data,
    output logic                  ifu_valid,
    input  logic                  ifu_ready,
    output logic [PC_WIDTH-1:0]   ifu_pc,
    output logic [INST_WIDTH-1:0] ifu_inst,
    input  logic                  redirect_vld,
    input  logic [PC_WIDTH-1:0]   redirect_pc
);

    if (DATA_WIDTH != INST_WIDTH) begin : g_bad_data_width
        $fatal(1, "ifu_fetch: DATA_WIDTH must equal INST_WIDTH");
    end
    if (PC_WIDTH != ADDR_WIDTH) begin : g_bad_addr_width
        $fatal(1, "ifu_fetch: PC_WIDTH must equal ADDR_WIDTH");
    end
    if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "ifu_fetch: FQ_DEPTH must be a power of two >= 2");
    end

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [PtrW-1:0]     used, unfilled;
    logic [PtrW:0]       inflight;
    logic                issue, resp_fill, resp_drop, q_fill, q_pop;

    // Old-stream responses still owed by memory count against the queue budget.
    assign inflight  = {1'b0, used} + {1'b0, drop_cnt_q};
    assign issue     = rst_n && !redirect_vld && (inflight < (PtrW+1)'(FQ_DEPTH));
    assign resp_fill = ifu_req_data_vld && (drop_cnt_q == '0);
    assign resp_drop = ifu_req_data_vld && (drop_cnt_q != '0);
    assign q_fill    = resp_fill && !redirect_vld;
    assign q_pop     = ifu_valid && ifu_ready && !redirect_vld;

    assign ifu_req_addr_vld = issue;
    assign ifu_req_addr     = fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(INST_BYTES);
        end
        if (resp_drop) begin
            drop_cnt_d = drop_cnt_q - PtrW'(1);
        end
        // Any response this cycle is old-stream: either already owed or now dropped.
        if (redirect_vld) begin
            fetch_pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
            drop_cnt_d = drop_cnt_q + unfilled - PtrW'(ifu_req_data_vld);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    ifu_fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_i     (issue),
        .alloc_pc_i  (fetch_pc_q),
        .fill_i      (q_fill),
        .fill_inst_i (ifu_req_data),
        .pop_i       (q_pop),
        .flush_i     (redirect_vld),
        .head_vld_o  (ifu_valid),
        .head_pc_o   (ifu_pc),
        .head_inst_o (ifu_inst),
        .used_o      (used),
        .unfilled_o  (unfilled)
    );

`ifdef IFU_FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (q_fill) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (ifu_req_data_vld && !q_fill) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule
